// File: rtl/sensor_uart_packetizer.sv
// -----------------------------------------------------------------------------
// sensor_uart_packetizer
//
// Purpose:
//   Captures each 72-bit ADS1292 RDATAC frame together with the 12-bit MPR121
//   touch status, then streams it to the host as a framed packet over a
//   UART transmitter (8N1, LSB first). The block has a one-deep holding
//   buffer, an 8-bit sequence number and a saturating drop counter.
//
//   Packet layout:
//     SYNC, SEQ, D[71:64] .. D[7:0], {4'h0,T[11:8]}, T[7:0] [, CHK]
//   CHK is the XOR of every byte from SEQ through T[7:0]. SYNC is not part
//   of the XOR.
//
// Configuration macro:
//   SENSOR_UART_CHECKSUM_EN  defined   -> 14-byte packet with trailing CHK
//                            undefined -> 13-byte packet, no XOR logic
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (legal >= 2)
//   SYNC_BYTE     first byte of every packet
//
// Ports:
//   i_CLK                  in   1   core clock, single domain
//   i_RST                  in   1   synchronous active-high reset
//   i_ADS1292_DATA         in   72  frame {status24, ch1_24, ch2_24}
//   i_ADS1292_VALID        in   1   one-cycle pulse qualifying the frame
//   i_MPR121_TOUCH_STATUS  in   12  touch bits, sampled with the frame
//   o_UART_TXD             out  1   serial output, idle high
//   o_BUSY                 out  1   packet in flight or frame held
//   o_DROP_CNT             out  8   frames discarded, saturates at 255
//   o_DBG_STATE            out  3   current FSM state (debug)
//
// Handshake: i_ADS1292_VALID is a push-only strobe with no ready/backpressure.
// A frame offered while the holding buffer is empty is always accepted; a
// frame offered while the holding buffer is full is discarded and counted.
// -----------------------------------------------------------------------------
module sensor_uart_packetizer #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic [71:0] i_ADS1292_DATA,
    input  logic        i_ADS1292_VALID,
    input  logic [11:0] i_MPR121_TOUCH_STATUS,
    output logic        o_UART_TXD,
    output logic        o_BUSY,
    output logic [7:0]  o_DROP_CNT,
    output logic [2:0]  o_DBG_STATE
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef SENSOR_UART_CHECKSUM_EN
    localparam logic [3:0] LAST_BYTE = 4'd13;
`else
    localparam logic [3:0] LAST_BYTE = 4'd12;
`endif

    state_t state;
    state_t next_state;

    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [3:0]        byte_idx;

    logic              hold_valid;
    logic [71:0]       hold_data;
    logic [11:0]       hold_touch;

    logic [71:0]       pkt_data;
    logic [11:0]       pkt_touch;
    logic [7:0]        pkt_seq;
    logic [7:0]        seq;
    logic [7:0]        drop_cnt;

    logic [7:0]        cur_byte;
    logic              baud_done;
    logic              last_byte;

    assign baud_done = (baud_cnt == BAUD_LAST);
    assign last_byte = (byte_idx == LAST_BYTE);

`ifdef SENSOR_UART_CHECKSUM_EN
    logic [7:0] pkt_chk;
    logic [7:0] chk_calc;

    // Checksum of the frame about to be loaded, using the sequence number it
    // will carry.
    always_comb begin
        chk_calc = seq ^ {4'h0, hold_touch[11:8]} ^ hold_touch[7:0];
        for (int i = 0; i < 9; i++) begin
            chk_calc = chk_calc ^ hold_data[i*8 +: 8];
        end
    end
`endif

    // ---------------------------------------------------------------- state
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (hold_valid) next_state = ST_LOAD;
            ST_LOAD:  next_state = ST_START;
            ST_START: if (baud_done) next_state = ST_DATA;
            ST_DATA:  if (baud_done && bit_idx == 3'd7) next_state = ST_STOP;
            ST_STOP: begin
                if (baud_done) begin
                    if (!last_byte) begin
                        next_state = ST_START;
                    // A frame arriving on the very last stop cycle lands in
                    // the buffer at this edge, so it chains straight to LOAD.
                    end else if (hold_valid || i_ADS1292_VALID) begin
                        next_state = ST_LOAD;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default:  next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            baud_cnt   <= '0;
            bit_idx    <= 3'd0;
            byte_idx   <= 4'd0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_touch <= '0;
            pkt_data   <= '0;
            pkt_touch  <= '0;
            pkt_seq    <= 8'd0;
            seq        <= 8'd0;
            drop_cnt   <= 8'd0;
`ifdef SENSOR_UART_CHECKSUM_EN
            pkt_chk    <= 8'd0;
`endif
        end else begin
            if (state == ST_START || state == ST_DATA || state == ST_STOP) begin
                baud_cnt <= baud_done ? '0 : baud_cnt + BAUD_W'(1);
            end else begin
                baud_cnt <= '0;
            end

            // Wraps 7 -> 0 on its own, ready for the next byte.
            if (state == ST_DATA && baud_done) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (state == ST_LOAD) begin
                byte_idx <= 4'd0;
            end else if (state == ST_STOP && baud_done) begin
                byte_idx <= byte_idx + 4'd1;
            end

            if (state == ST_LOAD) begin
                pkt_data  <= hold_data;
                pkt_touch <= hold_touch;
                pkt_seq   <= seq;
                seq       <= seq + 8'd1;
`ifdef SENSOR_UART_CHECKSUM_EN
                pkt_chk   <= chk_calc;
`endif
            end

            // Holding buffer. In LOAD the buffer is still full, so a frame
            // offered in that cycle is dropped rather than overwriting.
            if (i_ADS1292_VALID && !hold_valid) begin
                hold_data  <= i_ADS1292_DATA;
                hold_touch <= i_MPR121_TOUCH_STATUS;
                hold_valid <= 1'b1;
            end else begin
                if (state == ST_LOAD) begin
                    hold_valid <= 1'b0;
                end
                if (i_ADS1292_VALID && hold_valid && drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        cur_byte = 8'hFF;
        case (byte_idx)
            4'd0:    cur_byte = SYNC_BYTE;
            4'd1:    cur_byte = pkt_seq;
            4'd2:    cur_byte = pkt_data[71:64];
            4'd3:    cur_byte = pkt_data[63:56];
            4'd4:    cur_byte = pkt_data[55:48];
            4'd5:    cur_byte = pkt_data[47:40];
            4'd6:    cur_byte = pkt_data[39:32];
            4'd7:    cur_byte = pkt_data[31:24];
            4'd8:    cur_byte = pkt_data[23:16];
            4'd9:    cur_byte = pkt_data[15:8];
            4'd10:   cur_byte = pkt_data[7:0];
            4'd11:   cur_byte = {4'h0, pkt_touch[11:8]};
            4'd12:   cur_byte = pkt_touch[7:0];
`ifdef SENSOR_UART_CHECKSUM_EN
            4'd13:   cur_byte = pkt_chk;
`endif
            default: cur_byte = 8'hFF;
        endcase

        o_UART_TXD = 1'b1;
        case (state)
            ST_START: o_UART_TXD = 1'b0;
            ST_DATA:  o_UART_TXD = cur_byte[bit_idx];
            default:  o_UART_TXD = 1'b1;
        endcase

        o_BUSY      = (state != ST_IDLE) || hold_valid;
        o_DROP_CNT  = drop_cnt;
        o_DBG_STATE = state;
    end

endmodule

// File: tb/tb_sensor_uart_packetizer.sv
// -----------------------------------------------------------------------------
// tb_sensor_uart_packetizer
//
// Self-checking bench for sensor_uart_packetizer with CLKS_PER_BIT = 4.
// A UART monitor decodes o_UART_TXD and compares each byte against an
// expected-byte queue filled from a table of hand-computed vectors.
// Expected packet length follows SENSOR_UART_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_sensor_uart_packetizer;

    localparam int CPB = 4;
`ifdef SENSOR_UART_CHECKSUM_EN
    localparam int NB = 14;
`else
    localparam int NB = 13;
`endif
    localparam int PKT_CYC  = NB * 10 * CPB;
    localparam int BYTE_CYC = 10 * CPB;

    typedef struct {
        logic [71:0] data;
        logic [11:0] touch;
        logic [7:0]  seq;
        logic [7:0]  chk;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [71:0] data_in;
    logic        valid;
    logic [11:0] touch_in;
    logic        txd;
    logic        busy;
    logic [7:0]  drop_cnt;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic mon_en = 1'b0;

    logic [7:0] exp_q[$];
    int         fall_q[$];
    vec_t       vecs[4];
    vec_t       v_drop;

    sensor_uart_packetizer #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .i_CLK                (clk),
        .i_RST                (rst),
        .i_ADS1292_DATA       (data_in),
        .i_ADS1292_VALID      (valid),
        .i_MPR121_TOUCH_STATUS(touch_in),
        .o_UART_TXD           (txd),
        .o_BUSY               (busy),
        .o_DROP_CNT           (drop_cnt),
        .o_DBG_STATE          (dbg_state)
    );

    // ------------------------------------------------------ clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // --------------------------------------------------------------- checks
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // ------------------------------------------------------- UART monitor
    initial begin : monitor
        logic [7:0] rx;
        logic       stop_b;
        logic [7:0] e;
        int         t0;
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                t0 = cyc;
                repeat (2) @(negedge clk);
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB) @(negedge clk);
                    rx[b] = txd;
                end
                repeat (CPB) @(negedge clk);
                stop_b = txd;
                if (mon_en) begin
                    fall_q.push_back(t0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected got=%02h exp=none", rx);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", {24'h0, rx}, {24'h0, e});
                    end
                    check("rx_stop", {31'h0, stop_b}, 32'h1);
                end
            end
        end
    end

    // -------------------------------------------------------- driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        step(3);
        rst   = 1'b0;
    endtask

    task automatic send_frame(input vec_t v);
        data_in  = v.data;
        touch_in = v.touch;
        valid    = 1'b1;
        step(1);
        valid    = 1'b0;
    endtask

    task automatic push_pkt(input vec_t v);
        exp_q.push_back(8'hA5);
        exp_q.push_back(v.seq);
        for (int i = 8; i >= 0; i--) exp_q.push_back(v.data[i*8 +: 8]);
        exp_q.push_back({4'h0, v.touch[11:8]});
        exp_q.push_back(v.touch[7:0]);
`ifdef SENSOR_UART_CHECKSUM_EN
        exp_q.push_back(v.chk);
`endif
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            step(1);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout got=busy exp=idle");
        end
        step(4);
    endtask

    // ---------------------------------------------------------- main test
    initial begin
        int low_cnt;

        vecs[0] = '{data: 72'h0123456789ABCDEF01, touch: 12'h5A3, seq: 8'h00, chk: 8'hA7};
        vecs[1] = '{data: 72'h000000000000000000, touch: 12'hFFF, seq: 8'h01, chk: 8'hF1};
        vecs[2] = '{data: 72'hFFFFFFFFFFFFFFFFFF, touch: 12'h000, seq: 8'h02, chk: 8'hFD};
        vecs[3] = '{data: 72'h800000000000000001, touch: 12'h801, seq: 8'h03, chk: 8'h8B};
        v_drop  = '{data: 72'h111111111111111111, touch: 12'h123, seq: 8'h00, chk: 8'h00};

        data_in  = '0;
        touch_in = '0;
        valid    = 1'b0;

        // Reset state and quiet line.
        do_reset();
        check("rst_txd", {31'h0, txd}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_drop", {24'h0, drop_cnt}, 32'h0);
        check("rst_state", {29'h0, dbg_state}, 32'h0);
        low_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (txd !== 1'b1) low_cnt++;
        end
        check("idle_quiet", low_cnt, 0);

        // Table of single packets: content, latency and span.
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_pkt(vecs[i]);
            send_frame(vecs[i]);
            check("busy_after_valid", {31'h0, busy}, 32'h1);
            step(1);
            check("txd_in_load", {31'h0, txd}, 32'h1);
            check("state_load", {29'h0, dbg_state}, 32'h1);
            step(1);
            check("txd_start", {31'h0, txd}, 32'h0);
            step(PKT_CYC - 1);
            check("busy_last_stop", {31'h0, busy}, 32'h1);
            step(1);
            check("busy_done", {31'h0, busy}, 32'h0);
            check("txd_idle", {31'h0, txd}, 32'h1);
            step(4);
            check("vec_bytes_left", exp_q.size(), 0);
            check("vec_drop", {24'h0, drop_cnt}, 32'h0);
        end

        // Back-to-back packets with one drop.
        do_reset();
        fall_q.delete();
        push_pkt(vecs[0]);
        push_pkt(vecs[1]);
        send_frame(vecs[0]);
        step(20);
        send_frame(vecs[1]);
        step(20);
        send_frame(v_drop);
        check("b2b_drop", {24'h0, drop_cnt}, 32'h1);
        wait_idle(2 * PKT_CYC + 50);
        check("b2b_bytes_left", exp_q.size(), 0);
        check("b2b_byte_count", fall_q.size(), 2 * NB);
        if (fall_q.size() == 2 * NB) begin
            check("b2b_gap", fall_q[NB] - fall_q[NB-1], BYTE_CYC + 1);
        end
        check("b2b_drop_end", {24'h0, drop_cnt}, 32'h1);

        // Frame arriving on the final stop cycle goes to the buffer.
        do_reset();
        fall_q.delete();
        push_pkt(vecs[0]);
        push_pkt(vecs[1]);
        send_frame(vecs[0]);
        step(PKT_CYC + 1);
        send_frame(vecs[1]);
        check("laststop_drop", {24'h0, drop_cnt}, 32'h0);
        check("laststop_busy", {31'h0, busy}, 32'h1);
        check("laststop_state", {29'h0, dbg_state}, 32'h1);
        wait_idle(2 * PKT_CYC + 50);
        check("laststop_bytes_left", exp_q.size(), 0);
        check("laststop_byte_count", fall_q.size(), 2 * NB);
        if (fall_q.size() == 2 * NB) begin
            check("laststop_gap", fall_q[NB] - fall_q[NB-1], BYTE_CYC + 1);
        end

        // Drop counter saturation.
        do_reset();
        push_pkt(vecs[0]);
        push_pkt(vecs[1]);
        send_frame(vecs[0]);
        step(2);
        send_frame(vecs[1]);
        data_in  = v_drop.data;
        touch_in = v_drop.touch;
        valid    = 1'b1;
        step(254);
        check("sat_254", {24'h0, drop_cnt}, 32'hFE);
        step(1);
        check("sat_255", {24'h0, drop_cnt}, 32'hFF);
        step(45);
        valid = 1'b0;
        check("sat_hold", {24'h0, drop_cnt}, 32'hFF);
        wait_idle(2 * PKT_CYC + 50);
        check("sat_bytes_left", exp_q.size(), 0);

        // Reset in the middle of DATA bit 3 of byte 5.
        do_reset();
        mon_en = 1'b0;
        send_frame(vecs[0]);
        step(2 + 5 * BYTE_CYC + CPB + 3 * CPB + 1);
        check("midrst_state_data", {29'h0, dbg_state}, 32'h3);
        rst = 1'b1;
        step(1);
        check("midrst_txd", {31'h0, txd}, 32'h1);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_state", {29'h0, dbg_state}, 32'h0);
        rst = 1'b0;
        step(50);
        exp_q.delete();
        fall_q.delete();
        mon_en = 1'b1;
        push_pkt(vecs[0]);
        send_frame(vecs[0]);
        wait_idle(PKT_CYC + 50);
        check("midrst_bytes_left", exp_q.size(), 0);
        check("midrst_byte_count", fall_q.size(), NB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
